rv_alu: RTL and testbench
=========================

# rv_alu

Single-cycle-issue, registered-output integer ALU for the RV32I execute stage. It decodes the 32-bit instruction word, applies the selected operation to two 32-bit operands prepared by the operand-select logic, and registers the result one clock after `enable`. It sits between decode/operand-select and writeback.

## Interface
- No parameters; data width fixed at 32.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock, asynchronous, active-low.
- `instr`  in  32  RV32I instruction word (`instruction_t`); sampled when `enable`=1.
- `op1`  in  32  operand 1 (`register_t`): rs1, or upper immediate for LUI/AUIPC.
- `op2`  in  32  operand 2: rs2 (R-type) or sign-extended imm (I-type).
- `enable`  in  1  issue strobe; one operation per cycle when high.
- `result`  out  32  registered result.
- `instr_exec`  out  1  one-cycle pulse: `result` updated this cycle.

## Operation
- Decode uses opcode `instr[6:0]`, funct3 `instr[14:12]`, funct7 `instr[31:25]`.
- R-type (0110011), funct7=0000000: ADD(000), SLL(001), SLT(010), SLTU(011), XOR(100), SRL(101), OR(110), AND(111); funct7=0100000: SUB(000), SRA(101).
- I-type (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI use op2 as the immediate. SLLI/SRLI need funct7=0000000; SRAI needs funct7=0100000.
- LUI (0110111), AUIPC (0010111): result = op1. Upstream supplies the upper immediate or PC+imm.
- Arithmetic is modulo 2^32 with no overflow flag.
- SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Result is 1 or 0, zero-extended.
- Shift amount is `op2[4:0]`; upper bits of op2 are ignored. SRA replicates `op1[31]`.
- Illegal or unlisted encoding with `enable`=1: `result` holds its previous value and `instr_exec` stays 0.

## Timing
- Reset asserted: `result`=0 and `instr_exec`=0 immediately, held until deassertion.
- Latency 1: the edge that samples `enable`=1 loads `result`. `result` is valid after that edge and `instr_exec`=1 for that one cycle.
- `enable`=0: `result` holds and `instr_exec`=0.
- Back-to-back `enable`: throughput is one operation per cycle, and each result is visible for exactly one cycle.
- Reset mid-operation: the pending result is discarded and outputs clear asynchronously.
- Inputs are don't-care when `enable`=0.

## Configuration
- `ALU_MULDIV_EN` defined: R-type funct7=0000001 adds the following:
  - MUL(000): low 32 bits of the product.
  - MULH(001): high 32 bits, signed×signed.
  - MULHSU(010): high 32 bits, signed×unsigned.
  - MULHU(011): high 32 bits, unsigned×unsigned.
  - Latency is still 1.
- With the macro, funct3 100–111 under funct7=0000001 are illegal.
- Undefined: every funct7=0000001 encoding is illegal and no multiplier is synthesized.

## Test plan
- Reset: hold `rst`=0 for 5 cycles -> `result`=0, `instr_exec`=0. Then release.
- ADD: op1=0xFFFFFFFF, op2=1, `enable` one cycle -> next cycle `result`=0x00000000 with `instr_exec` pulse. Two cycles later `result` still 0 and `instr_exec`=0.
- Logic: op1=0xAAAA5555, op2=0x0F0F0F0F.
  - AND -> 0x0A0A0505.
  - OR -> 0xAFAF5F5F.
  - XOR -> 0xA5A55A5A.
- Shifts: op1=0x90ABCDEF, op2=0x00000024 (amount 4).
  - SLL -> 0x0ABCDEF0.
  - SRL -> 0x090ABCDE.
  - SRA -> 0xF90ABCDE.
- Compare: op1=0xFFFFFFFF (-1), op2=1.
  - SLT -> 1.
  - SLTU -> 0.
  - SUB -> 0xFFFFFFFE.
- Illegal/hold: issue opcode 0x7F after an ADD producing 3 -> `result` stays 3 and `instr_exec`=0.
- Back-to-back: ADD then AND on consecutive cycles -> two consecutive `instr_exec` pulses with the correct results in order.

Source files
------------

// File: rtl/rv_alu.sv
// rv_alu: RV32I execute-stage integer ALU with a registered result.
// Latency 1: the edge that samples enable=1 with a legal encoding loads result.
// No backpressure: one operation per cycle; illegal encodings hold result.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   instr      RV32I instruction word, sampled when enable=1
//   op1        rs1, or the upper immediate / PC+imm for LUI/AUIPC
//   op2        rs2 (R-type) or the sign-extended immediate (I-type)
//   enable     issue strobe
//   result     registered result
//   instr_exec one-cycle pulse: result was updated by the last edge
//
// Optional feature: define ALU_MULDIV_EN to add MUL/MULH/MULHSU/MULHU
// under R-type funct7=0000001. Without it those encodings are illegal
// and no multiplier exists.
module rv_alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        enable,
  output logic [31:0] result,
  output logic        instr_exec
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Only the low five bits of op2 are a shift amount; the rest are ignored.
  assign shamt  = op2[4:0];

  // Register-number and rd fields are resolved elsewhere in the pipeline.
  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  // Shared datapath terms; R-type and I-type differ only in legality.
  logic [31:0] add_val;
  logic [31:0] sub_val;
  logic [31:0] sll_val;
  logic [31:0] srl_val;
  logic [31:0] sra_val;
  logic [31:0] slt_val;
  logic [31:0] sltu_val;

  assign add_val  = op1 + op2;
  assign sub_val  = op1 - op2;
  assign sll_val  = op1 << shamt;
  assign srl_val  = op1 >> shamt;
  assign sra_val  = $unsigned($signed(op1) >>> shamt);
  assign slt_val  = {31'b0, ($signed(op1) < $signed(op2))};
  assign sltu_val = {31'b0, (op1 < op2)};

`ifdef ALU_MULDIV_EN
  // Each variant is a 64-bit product of suitably extended operands, so the
  // high word falls out of the correct signedness without correction terms.
  logic signed [63:0] mul_ss;
  logic signed [63:0] mul_su;
  logic        [63:0] mul_uu;

  assign mul_ss = $signed({{32{op1[31]}}, op1}) * $signed({{32{op2[31]}}, op2});
  assign mul_su = $signed({{32{op1[31]}}, op1}) * $signed({32'b0, op2});
  assign mul_uu = {32'b0, op1} * {32'b0, op2};

  logic unused_mul;
  assign unused_mul = ^{mul_su[31:0], mul_uu[31:0]};
`endif

  logic [31:0] alu_val;
  logic        alu_legal;

  always_comb begin
    alu_val   = '0;
    alu_legal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          alu_legal = 1'b1;
          unique case (funct3)
            3'b000:  alu_val = add_val;
            3'b001:  alu_val = sll_val;
            3'b010:  alu_val = slt_val;
            3'b011:  alu_val = sltu_val;
            3'b100:  alu_val = op1 ^ op2;
            3'b101:  alu_val = srl_val;
            3'b110:  alu_val = op1 | op2;
            default: alu_val = op1 & op2;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            alu_legal = 1'b1;
            alu_val   = sub_val;
          end else if (funct3 == 3'b101) begin
            alu_legal = 1'b1;
            alu_val   = sra_val;
          end
        end
`ifdef ALU_MULDIV_EN
        else if (funct7 == F7_MUL) begin
          // funct3 100-111 (divide group) stays illegal.
          alu_legal = ~funct3[2];
          unique case (funct3[1:0])
            2'b00:   alu_val = mul_ss[31:0];
            2'b01:   alu_val = mul_ss[63:32];
            2'b10:   alu_val = mul_su[63:32];
            default: alu_val = mul_uu[63:32];
          endcase
        end
`endif
      end
      OPC_OP_IMM: begin
        unique case (funct3)
          3'b000: begin alu_legal = 1'b1; alu_val = add_val;  end
          3'b010: begin alu_legal = 1'b1; alu_val = slt_val;  end
          3'b011: begin alu_legal = 1'b1; alu_val = sltu_val; end
          3'b100: begin alu_legal = 1'b1; alu_val = op1 ^ op2; end
          3'b110: begin alu_legal = 1'b1; alu_val = op1 | op2; end
          3'b111: begin alu_legal = 1'b1; alu_val = op1 & op2; end
          3'b001: begin
            alu_legal = (funct7 == F7_BASE);
            alu_val   = sll_val;
          end
          default: begin
            // funct3 101: the funct7 field selects logical vs arithmetic.
            if (funct7 == F7_BASE) begin
              alu_legal = 1'b1;
              alu_val   = srl_val;
            end else if (funct7 == F7_ALT) begin
              alu_legal = 1'b1;
              alu_val   = sra_val;
            end
          end
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        // Upstream already formed the upper immediate or PC+imm.
        alu_legal = 1'b1;
        alu_val   = op1;
      end
      default: begin
        alu_legal = 1'b0;
        alu_val   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result     <= '0;
      instr_exec <= 1'b0;
    end else begin
      instr_exec <= 1'b0;
      if (enable && alu_legal) begin
        result     <= alu_val;
        instr_exec <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv_alu.sv
// tb_rv_alu: randomized and directed checks of rv_alu against a reference model.
// Latency 1 is assumed: inputs driven on the falling edge, outputs sampled 1ns after the rising edge.
// No backpressure on the DUT; the bench issues at most one operation per cycle.
module tb_rv_alu;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        enable;
  logic [31:0] result;
  logic        instr_exec;

  int checks;
  int failures;

  logic [31:0] exp_res;
  logic        exp_exec;

  rv_alu dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .op1        (op1),
    .op2        (op2),
    .enable     (enable),
    .result     (result),
    .instr_exec (instr_exec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Instruction builders; register fields are arbitrary but fixed.
  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd4, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  // Reference model: plain 64-bit arithmetic from the RV32I definitions.
  function automatic void model(input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, output bit ok,
                                output logic [31:0] v);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint          prod;
    longint unsigned uprod;
    int              sh;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sh  = int'(b % 32);
    ok  = 1'b0;
    v   = 32'h0;
    if (opc == 7'b0110111 || opc == 7'b0010111) begin
      ok = 1'b1;
      v  = a;
    end else if (opc == 7'b0110011 || opc == 7'b0010011) begin
      bit is_r;
      is_r = (opc == 7'b0110011);
      if (is_r && f7 == 7'h01) begin
`ifdef ALU_MULDIV_EN
        if (f3 < 3'd4) begin
          ok = 1'b1;
          case (f3)
            3'd0: begin prod = sa * sb; v = prod[31:0]; end
            3'd1: begin prod = sa * sb; v = prod[63:32]; end
            3'd2: begin prod = sa * longint'(ub); v = prod[63:32]; end
            default: begin uprod = ua * ub; v = uprod[63:32]; end
          endcase
        end
`endif
      end else begin
        case (f3)
          3'd0: begin
            if (!is_r || f7 == 7'h00) begin ok = 1'b1; v = 32'(ua + ub); end
            else if (f7 == 7'h20)     begin ok = 1'b1; v = 32'(ua - ub); end
          end
          3'd1: begin
            ok = (f7 == 7'h00);
            v  = 32'(ua * (64'd1 << sh));
          end
          3'd2: begin ok = !is_r || f7 == 7'h00; v = (sa < sb) ? 32'd1 : 32'd0; end
          3'd3: begin ok = !is_r || f7 == 7'h00; v = (ua < ub) ? 32'd1 : 32'd0; end
          3'd4: begin ok = !is_r || f7 == 7'h00; v = a ^ b; end
          3'd5: begin
            if (f7 == 7'h00)      begin ok = 1'b1; v = 32'(ua / (64'd1 << sh)); end
            else if (f7 == 7'h20) begin ok = 1'b1; v = 32'(sa >>> sh); end
          end
          3'd6: begin ok = !is_r || f7 == 7'h00; v = a | b; end
          default: begin ok = !is_r || f7 == 7'h00; v = a & b; end
        endcase
      end
    end
  endfunction

  // One cycle: drive on the falling edge, check just after the rising edge.
  task automatic step(input bit en, input logic [31:0] ins, input logic [31:0] a,
                      input logic [31:0] b, input string tag);
    bit          ok;
    logic [31:0] v;
    @(negedge clk);
    enable = en;
    instr  = ins;
    op1    = a;
    op2    = b;
    model(ins, a, b, ok, v);
    @(posedge clk);
    #1;
    if (en && ok) begin
      exp_res  = v;
      exp_exec = 1'b1;
    end else begin
      exp_exec = 1'b0;
    end
    chk({tag, ".res"}, result, exp_res);
    chk({tag, ".exec"}, {31'b0, instr_exec}, {31'b0, exp_exec});
  endtask

  // Directed step that also pins the value to a hand-derived constant.
  task automatic op_const(input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want,
                          input string tag);
    step(1'b1, ins, a, b, tag);
    chk({tag, ".const"}, result, want);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_res  = 32'h0;
    exp_exec = 1'b0;
    rst      = 1'b0;
    enable   = 1'b0;
    instr    = 32'h0;
    op1      = 32'h0;
    op2      = 32'h0;

    // Reset held for five cycles.
    repeat (5) @(posedge clk);
    #1;
    chk("reset.res", result, 32'h0);
    chk("reset.exec", {31'b0, instr_exec}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ADD wraps modulo 2^32, then two idle cycles hold with no pulse.
    op_const(r_ins(7'h00, 3'd0), 32'hFFFF_FFFF, 32'h1, 32'h0, "add_wrap");
    step(1'b0, 32'h0, 32'h0, 32'h0, "idle1");
    step(1'b0, 32'h0, 32'h0, 32'h0, "idle2");

    // Logic operations.
    op_const(r_ins(7'h00, 3'd7), 32'hAAAA_5555, 32'h0F0F_0F0F, 32'h0A0A_0505, "and");
    op_const(r_ins(7'h00, 3'd6), 32'hAAAA_5555, 32'h0F0F_0F0F, 32'hAFAF_5F5F, "or");
    op_const(r_ins(7'h00, 3'd4), 32'hAAAA_5555, 32'h0F0F_0F0F, 32'hA5A5_5A5A, "xor");

    // Shifts: only op2[4:0] counts, so 0x24 shifts by 4.
    op_const(r_ins(7'h00, 3'd1), 32'h90AB_CDEF, 32'h24, 32'h0ABC_DEF0, "sll");
    op_const(r_ins(7'h00, 3'd5), 32'h90AB_CDEF, 32'h24, 32'h090A_BCDE, "srl");
    op_const(r_ins(7'h20, 3'd5), 32'h90AB_CDEF, 32'h24, 32'hF90A_BCDE, "sra");
    op_const(i_ins(7'h20, 3'd5), 32'h90AB_CDEF, 32'h24, 32'hF90A_BCDE, "srai");

    // Signed vs unsigned compares and subtraction.
    op_const(r_ins(7'h00, 3'd2), 32'hFFFF_FFFF, 32'h1, 32'h1, "slt");
    op_const(r_ins(7'h00, 3'd3), 32'hFFFF_FFFF, 32'h1, 32'h0, "sltu");
    op_const(r_ins(7'h20, 3'd0), 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, "sub");

    // Illegal opcode after ADD=3 holds the result without a pulse.
    op_const(r_ins(7'h00, 3'd0), 32'h1, 32'h2, 32'h3, "add3");
    step(1'b1, 32'h0000_007F, 32'h1234, 32'h5678, "illegal_opc");
    chk("illegal_opc.hold", result, 32'h3);
    step(1'b1, i_ins(7'h20, 3'd1), 32'h1, 32'h1, "illegal_slli");
    step(1'b1, r_ins(7'h20, 3'd7), 32'h1, 32'h1, "illegal_f7");
    step(1'b1, r_ins(7'h01, 3'd4), 32'h7, 32'h3, "illegal_div");

    // Back-to-back issue: two consecutive pulses, results in order.
    op_const(r_ins(7'h00, 3'd0), 32'h10, 32'h20, 32'h30, "b2b_add");
    op_const(r_ins(7'h00, 3'd7), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "b2b_and");

    // LUI passes op1 straight through.
    op_const({20'hABCDE, 5'd3, 7'b0110111}, 32'hABCD_E000, 32'h0, 32'hABCD_E000, "lui");

    // Randomized mix of legal, illegal and idle cycles.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0, 1:    ins = r_ins(f7, f3);
        2, 3:    ins = i_ins(f7, f3);
        4:       ins = {$urandom} & 32'hFFFF_FF80 | 32'h0000_0037;
        default: ins = $urandom;
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      step(($urandom_range(0, 4) != 0), ins, a, b, "rnd");
    end

    // Asynchronous reset in the middle of an issued operation.
    op_const(r_ins(7'h00, 3'd0), 32'h1, 32'h2, 32'h3, "pre_rst");
    @(negedge clk);
    enable = 1'b1;
    instr  = r_ins(7'h00, 3'd0);
    op1    = 32'h55;
    op2    = 32'h1;
    #2;
    rst = 1'b0;
    #1;
    exp_res  = 32'h0;
    exp_exec = 1'b0;
    chk("async_rst.res", result, 32'h0);
    chk("async_rst.exec", {31'b0, instr_exec}, 32'h0);
    @(posedge clk);
    #1;
    chk("async_rst.held", result, 32'h0);
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b1;
    step(1'b0, 32'h0, 32'h0, 32'h0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
